// File: rtl/add1p_result_align.sv
// Re-aligns the skewed LSB/MSB half-sums of the two-half adder into one word,
// buffers it in a small FIFO and counts words dropped under backpressure.
// Optional ALIGN_SATURATE_EN: clamp a carried-out word to all-ones.
module add1p_result_align #(
   parameter int WL    = 4,
   parameter int WM    = 4,
   parameter int DEPTH = 4,
   parameter int CNTW  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [WL-1:0]      lsb_sum,
   input  logic [WM-1:0]      msb_sum,
   input  logic               msb_carry,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WM+WL-1:0]   out_sum,
   output logic               out_carry,
   output logic               overrun,
   output logic [CNTW-1:0]    drop_cnt,
   input  logic               clr_stat
);
   localparam int W      = WM + WL;
   localparam int AW     = $clog2(DEPTH);
   localparam int STAGES = 2;

   typedef struct packed {
      logic         carry;
      logic [W-1:0] sum;
   } word_t;

   // vld_pipe[1] tags lsb_d (stage B), vld_pipe[2] tags align_q (stage C)
   logic [STAGES:1]        vld_pipe;
   logic [WL-1:0]          lsb_d;
   word_t                  align_q, align_n;
   word_t [DEPTH-1:0]      mem;
   logic [AW:0]            wptr, rptr;
   logic                   full, empty, push, pop, drop;

   always_comb begin
      align_n.sum   = {msb_sum, lsb_d};
      align_n.carry = msb_carry;
`ifdef ALIGN_SATURATE_EN
      if (msb_carry) align_n.sum = '1;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         lsb_d    <= '0;
         align_q  <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
         if (in_valid)    lsb_d   <= lsb_sum;
         if (vld_pipe[1]) align_q <= align_n;
      end
   end

   assign empty     = (wptr == rptr);
   assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   // a full FIFO still takes the word when its head leaves in the same cycle
   assign push      = vld_pipe[STAGES] && (!full || pop);
   assign drop      = vld_pipe[STAGES] && full && !pop;
   assign out_sum   = mem[rptr[AW-1:0]].sum;
   assign out_carry = mem[rptr[AW-1:0]].carry;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem  <= '0;
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) begin
            mem[wptr[AW-1:0]] <= align_q;
            wptr              <= wptr + (AW+1)'(1);
         end
         if (pop) rptr <= rptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun  <= 1'b0;
         drop_cnt <= '0;
      end else if (clr_stat) begin
         overrun  <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overrun <= 1'b1;
         if (drop_cnt != '1) drop_cnt <= drop_cnt + CNTW'(1);
      end
   end
endmodule

// File: tb/tb_add1p_result_align.sv
// Directed bench for add1p_result_align (WL=WM=4, DEPTH=4, CNTW=8).
module tb_add1p_result_align;
   logic       clk = 1'b0;
   logic       rst, in_valid, msb_carry, out_ready, clr_stat;
   logic [3:0] lsb_sum, msb_sum;
   logic       out_valid, out_carry, overrun;
   logic [7:0] out_sum, drop_cnt;
   int         n_chk = 0, n_pass = 0;

   add1p_result_align #(.WL(4), .WM(4), .DEPTH(4), .CNTW(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .lsb_sum(lsb_sum),
      .msb_sum(msb_sum), .msb_carry(msb_carry), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry),
      .overrun(overrun), .drop_cnt(drop_cnt), .clr_stat(clr_stat));

   always #5 clk = ~clk;

   // word k: lsb=k, msb=15-k
   function automatic logic [7:0] wd(input int k);
      wd = {4'(15 - k), 4'(k)};
   endfunction

   task automatic cyc(input logic v, input logic [3:0] l, input logic [3:0] m, input logic c);
      in_valid = v; lsb_sum = l; msb_sum = m; msb_carry = c;
      @(posedge clk); #1;
   endtask

   // n words back to back; ends in the cycle the last word sits in stage C
   task automatic send_seq(input int n, input int k0);
      for (int c = 0; c <= n; c++) cyc(c < n, 4'(k0 + c), 4'(15 - (k0 + c - 1)), 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 0; lsb_sum = 0; msb_sum = 0; msb_carry = 0;
      out_ready = 0; clr_stat = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 0; lsb_sum = 0; msb_sum = 0; msb_carry = 0;
      out_ready = 0; clr_stat = 0;
      #2;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", out_valid); else n_pass++;
      n_chk++; if (out_sum !== 8'h00) $display("FAIL rst_sum got %h exp 00", out_sum); else n_pass++;
      n_chk++; if (out_carry !== 1'b0) $display("FAIL rst_carry got %b exp 0", out_carry); else n_pass++;
      n_chk++; if (overrun !== 1'b0) $display("FAIL rst_overrun got %b exp 0", overrun); else n_pass++;
      n_chk++; if (drop_cnt !== 8'h00) $display("FAIL rst_drop_cnt got %h exp 00", drop_cnt); else n_pass++;
      do_reset();
   endtask

   task automatic test_single();
      do_reset(); out_ready = 1;
      cyc(1, 4'hA, 4'h0, 0);
      n_chk++; if (out_valid !== 1'b0) $display("FAIL single_c1 got %b exp 0", out_valid); else n_pass++;
      cyc(0, 4'h0, 4'h3, 0);
      n_chk++; if (out_valid !== 1'b0) $display("FAIL single_c2 got %b exp 0", out_valid); else n_pass++;
      cyc(0, 4'h0, 4'h0, 0);
      n_chk++;
      if ({out_valid, out_sum, out_carry} !== {1'b1, 8'h3A, 1'b0})
         $display("FAIL single_c3 got v=%b s=%h c=%b exp v=1 s=3a c=0", out_valid, out_sum, out_carry);
      else n_pass++;
      cyc(0, 4'h0, 4'h0, 0);
      n_chk++; if (out_valid !== 1'b0) $display("FAIL single_c4 got %b exp 0", out_valid); else n_pass++;
   endtask

   task automatic test_stream();
      do_reset(); out_ready = 1;
      for (int c = 0; c <= 18; c++) begin
         cyc(c < 16, 4'(c), 4'(15 - (c - 1)), 0);
         if (c >= 2 && c <= 17) begin
            n_chk++;
            if ({out_valid, out_sum, out_carry} !== {1'b1, wd(c - 2), 1'b0})
               $display("FAIL stream_w%0d got v=%b s=%h exp v=1 s=%h", c - 2, out_valid, out_sum, wd(c - 2));
            else n_pass++;
         end else begin
            n_chk++; if (out_valid !== 1'b0) $display("FAIL stream_idle_c%0d got %b exp 0", c + 1, out_valid); else n_pass++;
         end
      end
      n_chk++; if (drop_cnt !== 8'h00) $display("FAIL stream_drops got %h exp 00", drop_cnt); else n_pass++;
   endtask

   task automatic test_backpressure();
      do_reset(); out_ready = 0;
      send_seq(6, 1);
      cyc(0, 0, 0, 0);
      n_chk++; if (overrun !== 1'b1) $display("FAIL bp_overrun got %b exp 1", overrun); else n_pass++;
      n_chk++; if (drop_cnt !== 8'd2) $display("FAIL bp_drop_cnt got %0d exp 2", drop_cnt); else n_pass++;
      cyc(0, 0, 0, 0);
      n_chk++;
      if ({out_valid, out_sum} !== {1'b1, wd(1)})
         $display("FAIL bp_hold got v=%b s=%h exp v=1 s=%h", out_valid, out_sum, wd(1));
      else n_pass++;
      out_ready = 1;
      for (int i = 1; i <= 4; i++) begin
         n_chk++;
         if ({out_valid, out_sum} !== {1'b1, wd(i)})
            $display("FAIL bp_drain_w%0d got v=%b s=%h exp v=1 s=%h", i, out_valid, out_sum, wd(i));
         else n_pass++;
         cyc(0, 0, 0, 0);
      end
      n_chk++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %b exp 0", out_valid); else n_pass++;
   endtask

   task automatic test_full_pop();
      do_reset(); out_ready = 0;
      send_seq(5, 0);
      n_chk++; if (out_sum !== wd(0)) $display("FAIL fp_head got %h exp %h", out_sum, wd(0)); else n_pass++;
      out_ready = 1;
      cyc(0, 0, 0, 0);
      out_ready = 0;
      n_chk++; if ({overrun, drop_cnt} !== 9'h0) $display("FAIL fp_nodrop got ov=%b cnt=%0d exp 0/0", overrun, drop_cnt); else n_pass++;
      out_ready = 1;
      for (int i = 1; i <= 4; i++) begin
         n_chk++;
         if ({out_valid, out_sum} !== {1'b1, wd(i)})
            $display("FAIL fp_drain_w%0d got v=%b s=%h exp v=1 s=%h", i, out_valid, out_sum, wd(i));
         else n_pass++;
         cyc(0, 0, 0, 0);
      end
      n_chk++; if (out_valid !== 1'b0) $display("FAIL fp_empty got %b exp 0", out_valid); else n_pass++;
   endtask

   task automatic test_carry();
      logic [7:0] e1, e2;
`ifdef ALIGN_SATURATE_EN
      e1 = 8'hFF; e2 = 8'hFF;
`else
      e1 = 8'hEF; e2 = 8'h05;
`endif
      do_reset(); out_ready = 1;
      cyc(1, 4'hF, 4'h0, 0);
      cyc(1, 4'h5, 4'hE, 1);
      cyc(0, 4'h0, 4'h0, 1);
      n_chk++;
      if ({out_valid, out_sum, out_carry} !== {1'b1, e1, 1'b1})
         $display("FAIL carry_w0 got v=%b s=%h c=%b exp v=1 s=%h c=1", out_valid, out_sum, out_carry, e1);
      else n_pass++;
      cyc(0, 0, 0, 0);
      n_chk++;
      if ({out_valid, out_sum, out_carry} !== {1'b1, e2, 1'b1})
         $display("FAIL carry_w1 got v=%b s=%h c=%b exp v=1 s=%h c=1", out_valid, out_sum, out_carry, e2);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset(); out_ready = 0;
      for (int c = 0; c <= 4; c++) cyc(1, 4'(c), 4'(15 - (c - 1)), 0);
      n_chk++; if (out_valid !== 1'b1) $display("FAIL rm_pre got %b exp 1", out_valid); else n_pass++;
      #1 rst = 1'b1; in_valid = 0;
      #1;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL rm_async got %b exp 0", out_valid); else n_pass++;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; out_ready = 1;
      for (int c = 0; c < 6; c++) begin
         cyc(0, 0, 0, 0);
         n_chk++; if (out_valid !== 1'b0) $display("FAIL rm_stale_c%0d got %b exp 0", c, out_valid); else n_pass++;
      end
      n_chk++; if (drop_cnt !== 8'h00) $display("FAIL rm_drop_cnt got %0d exp 0", drop_cnt); else n_pass++;
   endtask

   task automatic test_clr_drop();
      do_reset(); out_ready = 0;
      send_seq(5, 0);
      clr_stat = 1;
      cyc(0, 0, 0, 0);
      clr_stat = 0;
      n_chk++; if ({overrun, drop_cnt} !== 9'h0) $display("FAIL clr_prio got ov=%b cnt=%0d exp 0/0", overrun, drop_cnt); else n_pass++;
      send_seq(1, 9);
      cyc(0, 0, 0, 0);
      n_chk++; if ({overrun, drop_cnt} !== {1'b1, 8'd1}) $display("FAIL clr_next got ov=%b cnt=%0d exp 1/1", overrun, drop_cnt); else n_pass++;
   endtask

   task automatic test_drop_sat();
      do_reset(); out_ready = 0;
      send_seq(300, 0);
      cyc(0, 0, 0, 0);
      n_chk++; if (drop_cnt !== 8'hFF) $display("FAIL sat_cnt got %0d exp 255", drop_cnt); else n_pass++;
      n_chk++; if (overrun !== 1'b1) $display("FAIL sat_overrun got %b exp 1", overrun); else n_pass++;
      clr_stat = 1;
      cyc(0, 0, 0, 0);
      clr_stat = 0;
      n_chk++; if ({overrun, drop_cnt} !== 9'h0) $display("FAIL sat_clr got ov=%b cnt=%0d exp 0/0", overrun, drop_cnt); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_full_pop();
      test_carry();
      test_reset_mid();
      test_clr_drop();
      test_drop_sat();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
